// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, FSM state type
// and default digit/timeout limits.
package atm_pkg;

    // Keypad codes above the decimal digits 0-9
    localparam logic [3:0] KEY_ENTER    = 4'hA;
    localparam logic [3:0] KEY_BORRAR   = 4'hB;
    localparam logic [3:0] KEY_CANCEL   = 4'hC;
    localparam logic [3:0] KEY_RETIRO   = 4'hD;
    localparam logic [3:0] KEY_DEPOSITO = 4'hE;

    localparam int unsigned PIN_DIGITS_DEF   = 4;
    localparam int unsigned MONTO_DIGITS_DEF = 9;
    localparam int unsigned TIMEOUT_CYC_DEF  = 1000000;

    typedef enum logic [2:0] {
        StIdle,
        StPinEntry,
        StPinWait,
        StTipoSel,
        StMontoEntry,
        StMontoWait,
        StLocked
    } atm_state_e;

endpackage

// File: rtl/atm_decimal_acc.sv
// Decimal accumulator: value <= value*10 + digit on load, with a digit counter
// that saturates the accumulator once MaxDigits digits have been counted.
module atm_decimal_acc #(
    parameter int unsigned Width     = 16,
    parameter int unsigned MaxDigits = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             count_en_i,
    input  logic [3:0]       digit_i,
    output logic [Width-1:0] value_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned CntW = $clog2(MaxDigits + 1);

    logic [Width-1:0] value_q, value_d;
    logic [CntW-1:0]  count_q, count_d;

    assign full_o  = (count_q == CntW'(MaxDigits));
    assign empty_o = (count_q == '0);
    assign value_o = value_q;

    // Next value: clear wins over load; loads past the digit limit are dropped
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr_i) begin
            value_d = '0;
            count_d = '0;
        end else if (load_i && !full_o) begin
            value_d = (value_q << 3) + (value_q << 1) + Width'(digit_i);
            if (count_en_i) begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    // Accumulator and counter registers, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: card detection, PIN collection, transaction type and
// amount entry feeding the ATM controller. All outputs are registered.
// Optional build macro KEYPAD_TIMEOUT_EN adds an inactivity timeout.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int unsigned PIN_DIGITS   = PIN_DIGITS_DEF,
    parameter int unsigned MONTO_DIGITS = MONTO_DIGITS_DEF,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tarjeta_insertada,
    input  logic        tecla_stb,
    input  logic [3:0]  tecla,
    input  logic        pin_incorrecto,
    input  logic        bloqueo,
    input  logic        balance_actualizado,
    input  logic        fondos_insuficientes,
    output logic        tarjeta_recibida,
    output logic        digito_stb,
    output logic [3:0]  digito,
    output logic [15:0] pin,
    output logic        pin_stb,
    output logic        tipo_trans,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        ocupado
);

    atm_state_e state_q, state_d;

    logic card_q;
    logic tarjeta_recibida_q, tarjeta_recibida_d;
    logic digito_stb_q, digito_stb_d;
    logic [3:0] digito_q, digito_d;
    logic pin_stb_q, pin_stb_d;
    logic monto_stb_q, monto_stb_d;
    logic tipo_trans_q, tipo_trans_d;
    logic ocupado_q;

    logic pin_clr, pin_load, pin_full, pin_empty;
    logic monto_clr, monto_load, monto_cnt_en, monto_full, monto_empty;

    // Decoded keys, valid only with the strobe
    logic key_digit, key_enter, key_borrar, key_cancel, key_tipo;
    logic card_edge, active, status_hit, timeout_hit;

    assign key_digit  = tecla_stb && (tecla <= 4'd9);
    assign key_enter  = tecla_stb && (tecla == KEY_ENTER);
    assign key_borrar = tecla_stb && (tecla == KEY_BORRAR);
    assign key_cancel = tecla_stb && (tecla == KEY_CANCEL);
    assign key_tipo   = tecla_stb && ((tecla == KEY_RETIRO) || (tecla == KEY_DEPOSITO));
    assign card_edge  = tarjeta_insertada && !card_q;
    assign active     = (state_q != StIdle) && (state_q != StLocked);

`ifdef KEYPAD_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic        timer_run;

    assign timer_run = (state_q == StPinEntry) || (state_q == StPinWait) ||
                       (state_q == StTipoSel) || (state_q == StMontoEntry);
    assign timeout_hit = timer_run && (timer_q >= TIMEOUT_CYC);

    // Inactivity counter restarts on any key or state change, frozen elsewhere
    always_comb begin
        timer_d = timer_q;
        if (tecla_stb || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_run && (timer_q < TIMEOUT_CYC)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Inactivity counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    // State and sensor-history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            card_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            card_q  <= tarjeta_insertada;
        end
    end

    // Next state; card removal beats controller status, which beats CANCEL
    always_comb begin
        state_d    = state_q;
        status_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (card_edge) state_d = StPinEntry;
            end
            StPinEntry: begin
                if (key_enter && pin_full) state_d = StPinWait;
            end
            // TIPO_SEL is an alias of PIN_WAIT and decodes identically
            StPinWait, StTipoSel: begin
                status_hit = bloqueo || pin_incorrecto;
                if (bloqueo) begin
                    state_d = StLocked;
                end else if (pin_incorrecto) begin
                    state_d = StPinEntry;
                end else if (key_tipo) begin
                    state_d = StMontoEntry;
                end
            end
            StMontoEntry: begin
                if (key_enter && (monto != 32'd0)) state_d = StMontoWait;
            end
            StMontoWait: begin
                status_hit = balance_actualizado || fondos_insuficientes;
                if (status_hit) state_d = StIdle;
            end
            StLocked: state_d = StLocked;
            default:  state_d = StIdle;
        endcase
        if (active && key_cancel && !status_hit) state_d = StIdle;
        if (active && (!tarjeta_insertada || timeout_hit)) state_d = StIdle;
    end

    // Output and datapath control derived from the chosen transition
    always_comb begin
        tarjeta_recibida_d = 1'b0;
        digito_stb_d       = 1'b0;
        digito_d           = digito_q;
        pin_stb_d          = 1'b0;
        monto_stb_d        = 1'b0;
        tipo_trans_d       = tipo_trans_q;
        pin_clr            = 1'b0;
        pin_load           = 1'b0;
        monto_clr          = 1'b0;
        monto_load         = 1'b0;
        monto_cnt_en       = 1'b0;
        if (state_d == StIdle) begin
            pin_clr      = 1'b1;
            monto_clr    = 1'b1;
            tipo_trans_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tarjeta_recibida_d = card_edge;
                end
                StPinEntry: begin
                    if (key_digit && !pin_full) begin
                        pin_load     = 1'b1;
                        digito_stb_d = 1'b1;
                        digito_d     = tecla;
                    end
                    if (key_borrar) pin_clr = 1'b1;
                    if (state_d == StPinWait) pin_stb_d = 1'b1;
                end
                StPinWait, StTipoSel: begin
                    if (state_d == StPinEntry) pin_clr = 1'b1;
                    if (state_d == StMontoEntry) tipo_trans_d = (tecla == KEY_RETIRO);
                end
                StMontoEntry: begin
                    if (key_digit) begin
                        monto_load = 1'b1;
                        // A leading zero leaves the value at 0 and is not counted
                        monto_cnt_en = !((tecla == 4'd0) && monto_empty);
                    end
                    if (key_borrar) monto_clr = 1'b1;
                    if (state_d == StMontoWait) monto_stb_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered strobes and held outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tarjeta_recibida_q <= 1'b0;
            digito_stb_q       <= 1'b0;
            digito_q           <= 4'd0;
            pin_stb_q          <= 1'b0;
            monto_stb_q        <= 1'b0;
            tipo_trans_q       <= 1'b0;
            ocupado_q          <= 1'b0;
        end else begin
            tarjeta_recibida_q <= tarjeta_recibida_d;
            digito_stb_q       <= digito_stb_d;
            digito_q           <= digito_d;
            pin_stb_q          <= pin_stb_d;
            monto_stb_q        <= monto_stb_d;
            tipo_trans_q       <= tipo_trans_d;
            ocupado_q          <= (state_d != StIdle);
        end
    end

    atm_decimal_acc #(
        .Width     (16),
        .MaxDigits (PIN_DIGITS)
    ) u_pin_acc (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (pin_clr),
        .load_i     (pin_load),
        .count_en_i (1'b1),
        .digit_i    (tecla),
        .value_o    (pin),
        .full_o     (pin_full),
        .empty_o    (pin_empty)
    );

    atm_decimal_acc #(
        .Width     (32),
        .MaxDigits (MONTO_DIGITS)
    ) u_monto_acc (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (monto_clr),
        .load_i     (monto_load),
        .count_en_i (monto_cnt_en),
        .digit_i    (tecla),
        .value_o    (monto),
        .full_o     (monto_full),
        .empty_o    (monto_empty)
    );

    logic unused_flags;
    assign unused_flags = pin_empty ^ monto_full;

    assign tarjeta_recibida = tarjeta_recibida_q;
    assign digito_stb       = digito_stb_q;
    assign digito           = digito_q;
    assign pin_stb          = pin_stb_q;
    assign monto_stb        = monto_stb_q;
    assign tipo_trans       = tipo_trans_q;
    assign ocupado          = ocupado_q;

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Front end for the ATM: debounced keypad codes and the card-slot sensor go in, and the block drives the controller's input side. It collects a 4-digit PIN, selects the transaction type and assembles a decimal amount. It presents `tarjeta_recibida`, `digito`/`digito_stb`, `pin`, `tipo_trans` and `monto`/`monto_stb` to the ATM controller, then reacts to the controller's status outputs. It sits between the keypad/card-reader pins and the ATM controller.

## Interface
- `PIN_DIGITS`, 4: digits per PIN.
- `MONTO_DIGITS`, 9: maximum amount digits; 999 999 999 fits in 32 bits.
- `TIMEOUT_CYC`, 1000000: inactivity limit; used only with `KEYPAD_TIMEOUT_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tarjeta_insertada`  in  1  card-present level from the slot sensor.
- `tecla_stb`  in  1  one-cycle pulse: key code valid.
- `tecla`  in  4  key code:
  - 0-9: digits
  - 0xA: ENTER
  - 0xB: BORRAR (clear buffer)
  - 0xC: CANCEL
  - 0xD: RETIRO
  - 0xE: DEPOSITO
  - 0xF: ignored
- `pin_incorrecto`, `bloqueo`, `balance_actualizado`, `fondos_insuficientes`  in  1 each  controller status.
- `tarjeta_recibida`  out  1  one-cycle pulse per card insertion.
- `digito_stb`  out  1  one-cycle pulse per accepted PIN digit.
- `digito`  out  4  last accepted PIN digit.
- `pin`  out  16  binary value of entered PIN.
- `pin_stb`  out  1  one-cycle pulse: PIN complete.
- `tipo_trans`  out  1  1 = retiro, 0 = deposito; held.
- `monto`  out  32  binary amount.
- `monto_stb`  out  1  one-cycle pulse: amount complete.
- `ocupado`  out  1  high in any state except IDLE.

## Operation
- **States:** IDLE, PIN_ENTRY, PIN_WAIT, TIPO_SEL, MONTO_ENTRY, MONTO_WAIT, LOCKED.
- **IDLE**
  - A rising edge of `tarjeta_insertada` pulses `tarjeta_recibida` and goes to PIN_ENTRY.
  - On entry, clear `pin`, `monto`, `tipo_trans` and the digit counter.
- **PIN_ENTRY**
  - Digit with count < `PIN_DIGITS`: `pin <= pin*10 + d`, count+1, pulse `digito_stb`, `digito <= d`.
  - Digit with count = `PIN_DIGITS`: ignored.
  - ENTER with count = `PIN_DIGITS`: pulse `pin_stb`, go to PIN_WAIT.
  - ENTER with fewer digits: ignored.
  - BORRAR: pin = 0, count = 0.
- **PIN_WAIT**
  - `bloqueo`: go to LOCKED.
  - `pin_incorrecto`: clear `pin` and count, go to PIN_ENTRY.
  - Otherwise any RETIRO/DEPOSITO key sets `tipo_trans`, go to MONTO_ENTRY. TIPO_SEL is an alias used when the type key arrives before the controller replies; behaviour is identical.
- **MONTO_ENTRY**
  - Same accumulator rule as PIN entry, 32-bit, limit `MONTO_DIGITS`.
  - A leading 0 with count = 0 is accepted but does not increment count.
  - ENTER with monto > 0: pulse `monto_stb`, go to MONTO_WAIT.
  - ENTER with monto = 0: ignored.
  - No `digito_stb` is issued in this state.
- **MONTO_WAIT**
  - `balance_actualizado` or `fondos_insuficientes`: go to IDLE.
- **LOCKED**
  - Only `rst` exits.
  - All keys are ignored; card removal is ignored.
- **Global aborts**
  - CANCEL in any state except IDLE/LOCKED: go to IDLE.
  - `tarjeta_insertada` low in any state except IDLE/LOCKED: go to IDLE.
- **Priority within one cycle:** rst > card removal > controller status > CANCEL > other keys.
- **Outputs** `pin`, `monto`, `tipo_trans` hold stable from their strobe until IDLE is re-entered.

## Timing
- All outputs are registered.
- Strobes assert in the cycle after the triggering `tecla_stb` or sensor edge and last exactly one cycle.
- `pin` is updated in the same cycle as `digito_stb`.
- `tarjeta_recibida` is asserted 1 cycle after the sampled 0→1 sensor edge. The edge detector uses one registered copy of the sensor.
- Reset values:
  - all outputs 0, state IDLE;
  - sensor history register 0, so a card already present at reset produces a pulse on the first cycle after reset.
- Back-to-back `tecla_stb` on consecutive cycles must each be processed.
- Multiply-by-10 is done as `(x<<3)+(x<<1)+d` in a single cycle. No overflow is possible within the digit limits.

## Configuration
- **`KEYPAD_TIMEOUT_EN` defined:**
  - an inactivity counter resets on every `tecla_stb` and on every state change;
  - reaching `TIMEOUT_CYC` in PIN_ENTRY, PIN_WAIT, TIPO_SEL or MONTO_ENTRY forces IDLE;
  - the counter is held in IDLE, LOCKED and MONTO_WAIT.
- **Undefined:** no counter is built, and states wait indefinitely.

## Structure
- **Package `atm_pkg`:**
  - key-code constants `KEY_ENTER`, `KEY_BORRAR`, `KEY_CANCEL`, `KEY_RETIRO`, `KEY_DEPOSITO`;
  - the state enum typedef;
  - the default digit limits.
- **Sub-module `atm_decimal_acc`:** parameterised-width decimal accumulator with clear/load-digit/count and a full flag. It is instantiated twice, once for the PIN (16 bits) and once for the amount (32 bits).

## Test plan
- **PIN entry:** insert card, keys 4,7,2,1,ENTER →
  - `tarjeta_recibida` pulse;
  - four `digito_stb` with `digito` 4,7,2,1;
  - `pin` = 4721, `pin_stb` one cycle.
- **Wrong PIN:** keys 4,7,2,BORRAR,1,2,3,4,ENTER, then `pin_incorrecto` →
  - `pin` = 1234 at strobe;
  - returns to PIN_ENTRY with `pin` = 0;
  - `ocupado` stays high.
- **Withdrawal:** valid PIN, RETIRO, keys 0,5,0,0,ENTER →
  - `tipo_trans` = 1, `monto` = 500, `monto_stb` pulse;
  - `fondos_insuficientes` returns to IDLE with outputs cleared.
- **Digit limits:** enter 10 amount digits of 9 → `monto` = 999999999; the 10th digit is ignored. ENTER with a 3-digit PIN → no `pin_stb`.
- **Aborts and lock:**
  - card removal mid-MONTO_ENTRY → IDLE next cycle;
  - `bloqueo` in PIN_WAIT → LOCKED; keys and a re-insert give no response until `rst`.
- **Timeout (`KEYPAD_TIMEOUT_EN`, `TIMEOUT_CYC` = 20):** no key for 20 cycles in PIN_ENTRY → IDLE, `ocupado` = 0.
